// File: rtl/alu_pkg.sv
// Shared definitions for the 20-bit ALU sequencer: widths, opcode encoding,
// status flag positions and the sequencer FSM state type.
package alu_pkg;

  localparam int W     = 20;
  localparam int OPC_W = 5;

  // Opcode encoding; codes 28..31 are undefined and behave like NOP.
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd0;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd1;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd2;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd3;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd4;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'd5;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'd6;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'd7;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'd8;
  localparam logic [OPC_W-1:0] OP_INC  = 5'd9;
  localparam logic [OPC_W-1:0] OP_DEC  = 5'd10;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd11;
  localparam logic [OPC_W-1:0] OP_ADC  = 5'd12;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd13;
  localparam logic [OPC_W-1:0] OP_SBC  = 5'd14;
  localparam logic [OPC_W-1:0] OP_SWAP = 5'd15;
  localparam logic [OPC_W-1:0] OP_EQ   = 5'd16;
  localparam logic [OPC_W-1:0] OP_LT   = 5'd17;
  localparam logic [OPC_W-1:0] OP_GT   = 5'd18;
  localparam logic [OPC_W-1:0] OP_LE   = 5'd19;
  localparam logic [OPC_W-1:0] OP_GE   = 5'd20;
  localparam logic [OPC_W-1:0] OP_JMP  = 5'd21;
  localparam logic [OPC_W-1:0] OP_JZ   = 5'd22;
  localparam logic [OPC_W-1:0] OP_JS   = 5'd23;
  localparam logic [OPC_W-1:0] OP_JZS  = 5'd24;
  localparam logic [OPC_W-1:0] OP_LSR  = 5'd25;
  localparam logic [OPC_W-1:0] OP_XSR  = 5'd26;
  localparam logic [OPC_W-1:0] OP_TRAP = 5'd27;

  // Status register layout is {C,S,Z}.
  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

  localparam logic [2:0] MASK_Z   = 3'b001;
  localparam logic [2:0] MASK_S   = 3'b010;
  localparam logic [2:0] MASK_ZS  = 3'b011;
  localparam logic [2:0] MASK_ALL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB1  = 2'd2,
    ST_WB2  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_core.sv
// Combinational ALU core: computes the result, candidate flags and which
// status bits the operation is allowed to update.
module alu_op_core
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             c_in,
  output logic [W-1:0]     result,
  output logic             z,
  output logic             s,
  output logic             c,
  output logic [2:0]       flag_mask,
  output logic             has_result
);

  // One extra bit so bit W holds carry-out, or borrow when subtracting.
  logic [W:0] wide;

  always_comb begin
    result     = '0;
    z          = 1'b0;
    s          = 1'b0;
    c          = c_in;
    flag_mask  = '0;
    has_result = 1'b0;
    wide       = '0;
    case (opcode)
      OP_NOT: begin result = ~a;    c = 1'b0; has_result = 1'b1; flag_mask = MASK_ALL; end
      OP_AND: begin result = a & b; c = 1'b0; has_result = 1'b1; flag_mask = MASK_ALL; end
      OP_OR:  begin result = a | b; c = 1'b0; has_result = 1'b1; flag_mask = MASK_ALL; end
      OP_XOR: begin result = a ^ b; c = 1'b0; has_result = 1'b1; flag_mask = MASK_ALL; end
      OP_SHL: begin
        result = {a[W-2:0], 1'b0}; c = a[W-1];
        has_result = 1'b1; flag_mask = MASK_ALL;
      end
      OP_SHR: begin
        result = {1'b0, a[W-1:1]}; c = a[0];
        has_result = 1'b1; flag_mask = MASK_ALL;
      end
      OP_ROL: begin result = {a[W-2:0], a[W-1]}; has_result = 1'b1; flag_mask = MASK_ZS; end
      OP_ROR: begin result = {a[0], a[W-1:1]};   has_result = 1'b1; flag_mask = MASK_ZS; end
      OP_INC: begin
        wide = {1'b0, a} + {{W{1'b0}}, 1'b1};
        result = wide[W-1:0]; c = wide[W]; has_result = 1'b1; flag_mask = MASK_ALL;
      end
      OP_DEC: begin
        wide = {1'b0, a} - {{W{1'b0}}, 1'b1};
        result = wide[W-1:0]; c = wide[W]; has_result = 1'b1; flag_mask = MASK_ALL;
      end
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        result = wide[W-1:0]; c = wide[W]; has_result = 1'b1; flag_mask = MASK_ALL;
      end
      OP_ADC: begin
        wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
        result = wide[W-1:0]; c = wide[W]; has_result = 1'b1; flag_mask = MASK_ALL;
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        result = wide[W-1:0]; c = wide[W]; has_result = 1'b1; flag_mask = MASK_ALL;
      end
      OP_SBC: begin
        wide = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c_in};
        result = wide[W-1:0]; c = wide[W]; has_result = 1'b1; flag_mask = MASK_ALL;
      end
      // First SWAP beat carries b; the sequencer supplies a on the second.
      OP_SWAP: begin result = b; c = 1'b0; has_result = 1'b1; flag_mask = MASK_ALL; end
      OP_EQ: begin z = (a == b); flag_mask = MASK_Z; end
      OP_LT: begin s = (a < b);  flag_mask = MASK_S; end
      OP_GT: begin s = (a > b);  flag_mask = MASK_S; end
      OP_LE: begin z = (a <= b); s = (a <= b); flag_mask = MASK_ZS; end
      OP_GE: begin z = (a >= b); s = !(a >= b); flag_mask = MASK_ZS; end
      default: ;
    endcase
    if (has_result) begin
      z = (result == '0);
      s = result[W-1];
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU sequencer: accepts one instruction per handshake, executes it through
// alu_op_core, owns the status register and emits result beats and jump pulses.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OPC_W-1:0] opcode,
  input  logic [W-1:0]     opnd_a,
  input  logic [W-1:0]     opnd_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_sel,
  output logic [2:0]       status,
  output logic             jmp_taken,
  output logic [W-1:0]     jmp_target,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a valid source holds its payload unchanged until that edge.

  state_t           state;
  logic [OPC_W-1:0] opc_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;

  logic [W-1:0] core_result;
  logic         core_z, core_s, core_c;
  logic [2:0]   core_mask;
  logic         core_has_result;
  logic [2:0]   next_status;
  logic         jump_take;

  assign dbg_state = state;

  alu_op_core u_core (
    .opcode     (opc_q),
    .a          (a_q),
    .b          (b_q),
    .c_in       (status[FLAG_C]),
    .result     (core_result),
    .z          (core_z),
    .s          (core_s),
    .c          (core_c),
    .flag_mask  (core_mask),
    .has_result (core_has_result)
  );

  // Flow ops see the status as it stood before this instruction.
  always_comb begin
    next_status = (status & ~core_mask) | ({core_c, core_s, core_z} & core_mask);
    jump_take   = 1'b0;
    case (opc_q)
      OP_LSR: next_status = a_q[2:0];
      OP_XSR: next_status = status ^ a_q[2:0];
      OP_JMP: jump_take = 1'b1;
      OP_JZ:  jump_take = status[FLAG_Z];
      OP_JS:  jump_take = status[FLAG_S];
      OP_JZS: jump_take = status[FLAG_Z] & status[FLAG_S];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_ready   <= 1'b1;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_sel    <= 1'b0;
      status     <= 3'b000;
      jmp_taken  <= 1'b0;
      jmp_target <= '0;
      opc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      jmp_taken <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            opc_q    <= opcode;
            a_q      <= opnd_a;
            b_q      <= opnd_b;
            op_ready <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          status <= next_status;
          if (jump_take) begin
            jmp_taken  <= 1'b1;
            jmp_target <= a_q;
          end
          if (core_has_result) begin
            res_valid <= 1'b1;
            res_sel   <= 1'b0;
            res_data  <= core_result;
            state     <= ST_WB1;
          end else begin
            op_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_WB1: begin
          if (res_ready) begin
            if (opc_q == OP_SWAP) begin
              res_data <= a_q;
              res_sel  <= 1'b1;
              state    <= ST_WB2;
            end else begin
              res_valid <= 1'b0;
              op_ready  <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        ST_WB2: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_sel   <= 1'b0;
            op_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus random
// instructions, checked against an arithmetic reference model via a scoreboard.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [OPC_W-1:0] opcode = '0;
  logic [W-1:0]     opnd_a = '0;
  logic [W-1:0]     opnd_b = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [W-1:0]     res_data;
  logic             res_sel;
  logic [2:0]       status;
  logic             jmp_taken;
  logic [W-1:0]     jmp_target;
  logic [1:0]       dbg_state;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .opcode     (opcode),
    .opnd_a     (opnd_a),
    .opnd_b     (opnd_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_sel    (res_sel),
    .status     (status),
    .jmp_taken  (jmp_taken),
    .jmp_target (jmp_target),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit rr_random = 1'b0;

  logic [W:0]   exp_q[$];      // {sel, data} beats in order
  logic [W-1:0] exp_jmp_q[$];  // expected jump targets
  logic         m_z = 1'b0, m_s = 1'b0, m_c = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_op(input logic [OPC_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint m    = longint'(1) << W;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint cin  = longint'(m_c);
    longint t    = 0;
    longint r    = 0;
    bit     has_r = 1'b0;
    logic   nc   = m_c;
    logic [W-1:0] rv;
    case (op)
      OP_NOT:  begin r = m - 1 - ua; nc = 1'b0; has_r = 1'b1; end
      OP_AND:  begin r = longint'(a & b); nc = 1'b0; has_r = 1'b1; end
      OP_OR:   begin r = longint'(a | b); nc = 1'b0; has_r = 1'b1; end
      OP_XOR:  begin r = longint'(a ^ b); nc = 1'b0; has_r = 1'b1; end
      OP_SHL:  begin r = (ua * 2) % m; nc = (ua >= m / 2); has_r = 1'b1; end
      OP_SHR:  begin r = ua / 2; nc = (ua % 2 == 1); has_r = 1'b1; end
      OP_ROL:  begin r = (ua * 2) % m + ua / (m / 2); has_r = 1'b1; end
      OP_ROR:  begin r = ua / 2 + (ua % 2) * (m / 2); has_r = 1'b1; end
      OP_INC:  begin t = ua + 1; nc = (t >= m); r = t % m; has_r = 1'b1; end
      OP_DEC:  begin t = ua - 1; nc = (t < 0); r = (t + m) % m; has_r = 1'b1; end
      OP_ADD:  begin t = ua + ub; nc = (t >= m); r = t % m; has_r = 1'b1; end
      OP_ADC:  begin t = ua + ub + cin; nc = (t >= m); r = t % m; has_r = 1'b1; end
      OP_SUB:  begin t = ua - ub; nc = (t < 0); r = (t + m) % m; has_r = 1'b1; end
      OP_SBC:  begin t = ua - ub - cin; nc = (t < 0); r = (t + m) % m; has_r = 1'b1; end
      OP_SWAP: begin r = ub; nc = 1'b0; has_r = 1'b1; end
      OP_EQ:   m_z = (a == b);
      OP_LT:   m_s = (a < b);
      OP_GT:   m_s = (a > b);
      OP_LE:   begin m_z = (a <= b); m_s = (a <= b); end
      OP_GE:   begin m_z = (a >= b); m_s = !(a >= b); end
      OP_JMP:  exp_jmp_q.push_back(a);
      OP_JZ:   if (m_z) exp_jmp_q.push_back(a);
      OP_JS:   if (m_s) exp_jmp_q.push_back(a);
      OP_JZS:  if (m_z && m_s) exp_jmp_q.push_back(a);
      OP_LSR:  {m_c, m_s, m_z} = a[2:0];
      OP_XSR:  {m_c, m_s, m_z} = {m_c, m_s, m_z} ^ a[2:0];
      default: ;
    endcase
    if (has_r) begin
      rv = r[W-1:0];
      exp_q.push_back({1'b0, rv});
      if (op == OP_SWAP) exp_q.push_back({1'b1, a});
      m_z = (r == 0);
      m_s = (r >= m / 2);
      m_c = nc;
    end
  endtask

  // ---------------- driver tasks (called at posedge + 2) ----------------
  task automatic issue_op(input logic [OPC_W-1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    int budget = 0;
    model_op(opc, a, b);
    opcode   = opc;
    opnd_a   = a;
    opnd_b   = b;
    op_valid = 1'b1;
    while (!op_ready && budget < 60) begin
      @(posedge clk); #2;
      budget++;
    end
    check("accept_ready", op_ready, 1);
    @(posedge clk); #2;
    op_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    while (!op_ready && budget < 60) begin
      @(posedge clk); #2;
      budget++;
    end
    check("done_ready", op_ready, 1);
    check("status", status, {m_c, m_s, m_z});
  endtask

  task automatic wait_res_valid();
    int budget = 0;
    while (!res_valid && budget < 20) begin
      @(posedge clk); #2;
      budget++;
    end
    check("res_valid_seen", res_valid, 1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 20'h80000;
      default: return W'($urandom);
    endcase
  endfunction

  initial forever begin
    @(posedge clk); #2;
    if (rr_random) res_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic       hold = 1'b0;
    logic [W:0] held = '0;
    logic [W:0] exp_beat;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", res_valid, 1);
          check("hold_beat", {res_sel, res_data}, held);
        end
        if (res_valid && res_ready) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_beat = exp_q.pop_front();
            check("beat", {res_sel, res_data}, exp_beat);
          end
        end
        if (jmp_taken) begin
          check("jmp_expected", exp_jmp_q.size() != 0, 1);
          if (exp_jmp_q.size() != 0) check("jmp_target", jmp_target, exp_jmp_q.pop_front());
        end
        hold = res_valid && !res_ready;
        held = {res_sel, res_data};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_op_ready", op_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_sel", res_sel, 0);
    check("rst_status", status, 3'b000);
    check("rst_jmp_taken", jmp_taken, 0);
    check("rst_jmp_target", jmp_target, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    // ADD wrap: latency and flags
    res_ready = 1'b1;
    issue_op(OP_ADD, 20'hFFFFF, 20'h00001);
    check("lat_exec_no_valid", res_valid, 0);
    @(posedge clk); #2;
    check("lat_valid_by_edge2", res_valid, 1);
    check("add_data", res_data, 20'h00000);
    wait_done();
    check("add_status_csz", status, 3'b101);

    // SWAP with backpressure
    res_ready = 1'b0;
    issue_op(OP_SWAP, 20'h12345, 20'hABCDE);
    wait_res_valid();
    check("swap_b1_data", res_data, 20'hABCDE);
    check("swap_b1_sel", res_sel, 0);
    repeat (3) begin @(posedge clk); #2; end
    check("swap_b1_held", res_data, 20'hABCDE);
    res_ready = 1'b1;
    @(posedge clk); #2;
    check("swap_b2_data", res_data, 20'h12345);
    check("swap_b2_sel", res_sel, 1);
    wait_done();

    // Conditional jump on status
    issue_op(OP_LSR, 20'h00003, 20'h0); wait_done();
    issue_op(OP_JZS, 20'h00400, 20'h0); wait_done();
    issue_op(OP_LSR, 20'h00001, 20'h0); wait_done();
    issue_op(OP_JZS, 20'h00500, 20'h0); wait_done();
    repeat (3) begin @(posedge clk); #2; end
    check("jzs_pulses_consumed", exp_jmp_q.size(), 0);

    // Carry-in arithmetic
    issue_op(OP_LSR, 20'h00004, 20'h0); wait_done();
    issue_op(OP_ADC, 20'h00001, 20'h00001); wait_done();
    check("adc_status", status, 3'b000);
    issue_op(OP_LSR, 20'h00004, 20'h0); wait_done();
    issue_op(OP_SBC, 20'h00000, 20'h00000); wait_done();
    check("sbc_status", status, 3'b110);

    // Compare without beat, then an op held while busy
    issue_op(OP_GE, 20'h00005, 20'h00007); wait_done();
    check("ge_zs", status[1:0], 2'b10);
    issue_op(OP_XOR, 20'h0F0F0, 20'h00FF0);
    check("busy_not_ready", op_ready, 0);
    issue_op(OP_INC, 20'hFFFFF, 20'h0);
    wait_done();

    // Reset while a beat is pending in WB1
    res_ready = 1'b0;
    issue_op(OP_LSR, 20'h00007, 20'h0); wait_done();
    issue_op(OP_ADD, 20'h00010, 20'h00020);
    wait_res_valid();
    rst = 1'b1;
    #1;
    check("midrst_res_valid", res_valid, 0);
    check("midrst_status", status, 3'b000);
    check("midrst_op_ready", op_ready, 1);
    exp_q.delete();
    {m_c, m_s, m_z} = 3'b000;
    @(posedge clk); #2;
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (4) begin @(posedge clk); #2; end

    // Random instructions with random backpressure
    rr_random = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = pick_operand();
      rb = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
      issue_op(OPC_W'($urandom_range(0, 31)), ra, rb);
      wait_done();
    end
    rr_random = 1'b0;
    res_ready = 1'b1;
    repeat (5) begin @(posedge clk); #2; end
    check("beats_drained", exp_q.size(), 0);
    check("jumps_drained", exp_jmp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
